switch_filter: RTL and testbench

Input conditioner for the 24 board DIP switches. Synchronises each raw pin into the `switclk` domain, debounces it with a per-bit stability counter, and drives the clean 24-bit `switch_i` bus read by the memory-mapped switch port. It also produces a one-cycle change pulse and, optionally, a sticky change flag for software polling.

---
 rtl/switch_filter.sv | 60 ++++++
 tb/tb_switch_filter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_filter.sv
// switch_filter: synchronises and debounces the 24 board DIP switches, with a one-cycle change pulse.
// Define SWITCH_CHG_FLAG_EN to add the sticky chg_flag output and its chg_clr input.
module switch_filter #(
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 4
) (
  input  logic        switclk,
  input  logic        switrst,
  input  logic [23:0] switch_raw,
  output logic [23:0] switch_i,
  output logic        sw_changed
`ifdef SWITCH_CHG_FLAG_EN
  ,
  output logic        chg_flag,
  input  logic        chg_clr
`endif
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  logic [23:0]   r_s1, r_s2;
  logic [TW-1:0] r_div;
  logic [CW-1:0] r_cnt [24];
  logic [CW-1:0] w_cnt_nxt [24];
  logic [23:0]   w_flip;
  logic          w_tick;
  assign w_tick = r_div == TICK_LAST;
  // A bit flips on the tick that would complete its STABLE_CNT-th consecutive mismatch.
  always_comb begin
    w_flip = '0;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < 24; i++) begin
      w_flip[i] = w_tick && r_s2[i] != switch_i[i] && r_cnt[i] == CNT_LAST;
      w_cnt_nxt[i] = !w_tick ? r_cnt[i] : (r_s2[i] == switch_i[i] || w_flip[i]) ? '0 : r_cnt[i] + 1'b1;
    end
  end
  always_ff @(posedge switclk or posedge switrst)
    if (switrst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_div      <= '0;
      r_cnt      <= '{default: '0};
      switch_i   <= '0;
      sw_changed <= 1'b0;
    end else begin
      r_s1       <= switch_raw;
      r_s2       <= r_s1;
      r_div      <= w_tick ? '0 : r_div + 1'b1;
      r_cnt      <= w_cnt_nxt;
      switch_i   <= switch_i ^ w_flip;
      sw_changed <= |w_flip;
    end
`ifdef SWITCH_CHG_FLAG_EN
  // Set has priority so a clear racing a pulse never loses the event.
  always_ff @(posedge switclk or posedge switrst)
    if (switrst) chg_flag <= 1'b0;
    else chg_flag <= sw_changed | (chg_flag & ~chg_clr);
`endif
endmodule

// File: tb/tb_switch_filter.sv
// tb_switch_filter: randomized and directed checks of switch_filter against a streak-counting reference model.
module tb_switch_filter;
  localparam int TD = 4;
  localparam int SC = 3;
  logic        switclk = 1'b0;
  logic        switrst = 1'b0;
  logic [23:0] switch_raw = '0;
  logic [23:0] switch_i;
  logic        sw_changed;
  int          n_checks = 0;
  int          n_pass = 0;
`ifdef SWITCH_CHG_FLAG_EN
  logic chg_clr = 1'b0;
  logic chg_flag;
  logic m_flag;
`endif

  switch_filter #(.TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .switclk(switclk),
    .switrst(switrst),
    .switch_raw(switch_raw),
    .switch_i(switch_i),
`ifdef SWITCH_CHG_FLAG_EN
    .chg_flag(chg_flag),
    .chg_clr(chg_clr),
`endif
    .sw_changed(sw_changed)
  );

  always #5 switclk = ~switclk;

  // Reference: raw seen two edges late; every TD-th edge after reset is a sample point;
  // a bit flips once it has disagreed with the output for SC sample points in a row.
  logic [23:0] m_d1, m_d2, m_out, m_flip;
  logic        m_chg, m_tick;
  int          m_edge;
  int          m_run [24];
  assign m_tick = ((m_edge + 1) % TD) == 0;
  always_comb begin
    m_flip = '0;
    for (int i = 0; i < 24; i++) m_flip[i] = m_tick && (m_d2[i] != m_out[i]) && (m_run[i] + 1 == SC);
  end
  always @(posedge switclk or posedge switrst)
    if (switrst) begin
      m_d1 <= '0; m_d2 <= '0; m_out <= '0; m_chg <= 1'b0; m_edge <= 0;
      m_run <= '{default: 0};
`ifdef SWITCH_CHG_FLAG_EN
      m_flag <= 1'b0;
`endif
    end else begin
      m_edge <= m_edge + 1;
      m_d1 <= switch_raw;
      m_d2 <= m_d1;
      for (int i = 0; i < 24; i++)
        if (m_tick) m_run[i] <= (m_d2[i] == m_out[i] || m_flip[i]) ? 0 : m_run[i] + 1;
      m_out <= m_out ^ m_flip;
      m_chg <= |m_flip;
`ifdef SWITCH_CHG_FLAG_EN
      m_flag <= m_chg | (m_flag & ~chg_clr);
`endif
    end

  task automatic test_reset();
    int pulses = 0, first_hi = -1;
    switch_raw = 24'hFFFFFF;
    switrst = 1'b1;
    #1;
    n_checks++;
    if (switch_i !== 24'h0 || sw_changed !== 1'b0) $display("FAIL reset_in switch_i=%h sw_changed=%b expected 000000 0", switch_i, sw_changed);
    else n_pass++;
    @(negedge switclk);
    @(negedge switclk) switrst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge switclk);
      if (sw_changed) pulses++;
      if (first_hi < 0 && switch_i === 24'hFFFFFF) first_hi = c;
      n_checks++;
      if (switch_i !== m_out || sw_changed !== m_chg) $display("FAIL reset_model c=%0d switch_i=%h sw_changed=%b expected %h %b", c, switch_i, sw_changed, m_out, m_chg);
      else n_pass++;
    end
    n_checks++;
    if (first_hi < 11 || first_hi > 14) $display("FAIL reset_latency first_all_ones=%0d expected 11..14", first_hi);
    else n_pass++;
    n_checks++;
    if (pulses != 1) $display("FAIL reset_pulses got=%0d expected 1", pulses);
    else n_pass++;
  endtask

  task automatic test_single_bit();
    int pulses = 0, first_hi = -1;
    switch_raw = 24'h0;
    switrst = 1'b1;
    @(negedge switclk) switrst = 1'b0;
    repeat (8) @(negedge switclk);
    switch_raw = 24'h000001;
    for (int c = 1; c <= 20; c++) begin
      @(negedge switclk);
      if (sw_changed) pulses++;
      if (first_hi < 0 && switch_i[0] === 1'b1) first_hi = c;
      n_checks++;
      if (switch_i !== m_out || sw_changed !== m_chg) $display("FAIL single_model c=%0d switch_i=%h sw_changed=%b expected %h %b", c, switch_i, sw_changed, m_out, m_chg);
      else n_pass++;
    end
    n_checks++;
    if (first_hi < 2 + (SC - 1) * TD + 1 || first_hi > 2 + SC * TD) $display("FAIL single_latency got=%0d expected %0d..%0d", first_hi, 2 + (SC - 1) * TD + 1, 2 + SC * TD);
    else n_pass++;
    n_checks++;
    if (pulses != 1 || switch_i !== 24'h000001) $display("FAIL single_result pulses=%0d switch_i=%h expected 1 000001", pulses, switch_i);
    else n_pass++;
`ifdef SWITCH_CHG_FLAG_EN
    n_checks++;
    if (chg_flag !== 1'b1) $display("FAIL single_flag got=%b expected 1", chg_flag);
    else n_pass++;
`endif
  endtask

  task automatic test_glitch();
    int pulses = 0;
`ifdef SWITCH_CHG_FLAG_EN
    chg_clr = 1'b1;
    @(negedge switclk) chg_clr = 1'b0;
`endif
    switch_raw = 24'h000021;
    for (int c = 1; c <= 25; c++) begin
      @(negedge switclk);
      if (c == 5) switch_raw = 24'h000001;
      if (sw_changed) pulses++;
      n_checks++;
      if (switch_i !== m_out || sw_changed !== m_chg) $display("FAIL glitch_model c=%0d switch_i=%h sw_changed=%b expected %h %b", c, switch_i, sw_changed, m_out, m_chg);
      else n_pass++;
    end
    n_checks++;
    if (pulses != 0 || switch_i !== 24'h000001) $display("FAIL glitch_result pulses=%0d switch_i=%h expected 0 000001", pulses, switch_i);
    else n_pass++;
`ifdef SWITCH_CHG_FLAG_EN
    n_checks++;
    if (chg_flag !== 1'b0) $display("FAIL glitch_flag got=%b expected 0", chg_flag);
    else n_pass++;
`endif
  endtask

  task automatic test_multi();
    int pulses = 0;
    bit seen = 0;
    switch_raw = 24'hA50001;
    for (int c = 1; c <= 20; c++) begin
      @(negedge switclk);
      if (sw_changed) pulses++;
      if (!seen && switch_i[23:16] !== 8'h00) begin
        seen = 1;
        n_checks++;
        if (switch_i[23:16] !== 8'hA5) $display("FAIL multi_edge got=%h expected a5", switch_i[23:16]);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 1 || switch_i !== 24'hA50001) $display("FAIL multi_result pulses=%0d switch_i=%h expected 1 a50001", pulses, switch_i);
    else n_pass++;
  endtask

  task automatic test_flag_race();
`ifdef SWITCH_CHG_FLAG_EN
    bit found = 0;
    switch_raw = 24'hA50003;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge switclk);
      if (sw_changed === 1'b1) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL race_timeout sw_changed=%b expected a pulse within 30 cycles", sw_changed);
    else n_pass++;
    chg_clr = 1'b1;
    @(negedge switclk);
    n_checks++;
    if (chg_flag !== 1'b1) $display("FAIL race_set_wins got=%b expected 1", chg_flag);
    else n_pass++;
    @(negedge switclk);
    n_checks++;
    if (chg_flag !== 1'b0) $display("FAIL race_clear got=%b expected 0", chg_flag);
    else n_pass++;
    chg_clr = 1'b0;
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge switclk);
      n_checks++;
      if (switch_i !== m_out || sw_changed !== m_chg) $display("FAIL rand_model c=%0d switch_i=%h sw_changed=%b expected %h %b", c, switch_i, sw_changed, m_out, m_chg);
      else n_pass++;
`ifdef SWITCH_CHG_FLAG_EN
      n_checks++;
      if (chg_flag !== m_flag) $display("FAIL rand_flag c=%0d got=%b expected %b", c, chg_flag, m_flag);
      else n_pass++;
      chg_clr = $urandom_range(5) == 0;
`endif
      if ($urandom_range(7) == 0) switch_raw = switch_raw ^ (24'($urandom) & 24'($urandom));
    end
`ifdef SWITCH_CHG_FLAG_EN
    chg_clr = 1'b0;
`endif
  endtask

  task automatic test_mid_reset();
    int first_hi = -1;
    bit found = 0;
    switch_raw = 24'hFFFFF7;
    repeat (30) @(negedge switclk);
    switch_raw = 24'hFFFFFF;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge switclk);
      if (m_run[3] == 2) found = 1;
    end
    n_checks++;
    if (!found || switch_i !== 24'hFFFFF7) $display("FAIL mid_precount found=%0d switch_i=%h expected 1 fffff7", found, switch_i);
    else n_pass++;
    switrst = 1'b1;
    #1;
    n_checks++;
    if (switch_i !== 24'h0 || sw_changed !== 1'b0) $display("FAIL mid_reset_out switch_i=%h sw_changed=%b expected 000000 0", switch_i, sw_changed);
    else n_pass++;
`ifdef SWITCH_CHG_FLAG_EN
    n_checks++;
    if (chg_flag !== 1'b0) $display("FAIL mid_reset_flag got=%b expected 0", chg_flag);
    else n_pass++;
`endif
    @(negedge switclk) switrst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge switclk);
      if (first_hi < 0 && switch_i[3] === 1'b1) first_hi = c;
    end
    n_checks++;
    if (first_hi != 2 + SC * TD - 2) $display("FAIL mid_latency got=%0d expected %0d", first_hi, 2 + SC * TD - 2);
    else n_pass++;
    n_checks++;
    if (switch_i !== 24'hFFFFFF) $display("FAIL mid_final got=%h expected ffffff", switch_i);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_glitch();
    test_multi();
    test_flag_race();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
